// File: rtl/ibf_cfg_loader_pkg.sv
// Shared encodings for the IBF config loader: bank targets, FSM states and
// the config bus width that ibf_top must agree on.
package ibf_cfg_loader_pkg;

  localparam int CFG_BUS_WIDTH_DEF = 64;

  typedef enum logic {
    TGT_2_2 = 1'b0,
    TGT_2_1 = 1'b1
  } tgt_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD_22 = 2'd1,
    ST_LOAD_21 = 2'd2
  } state_e;

  // Beat counter width: enough for the larger bank, never narrower than 1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ibf_cfg_loader_if.sv
// Command, config-word stream, status and both SRAM write ports of the loader.
interface ibf_cfg_loader_if #(
  parameter int CFG_BUS_WIDTH = 64,
  parameter int MODE_WIDTH    = 2,
  parameter int SEL_WIDTH_2_2 = 8,
  parameter int SEL_WIDTH_2_1 = 4
);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_target;
  logic [MODE_WIDTH-1:0]    cmd_addr;

  logic                     s_valid;
  logic                     s_ready;
  logic [CFG_BUS_WIDTH-1:0] s_data;

  logic                     busy;
  logic                     done;
  logic                     err;

  logic [SEL_WIDTH_2_2-1:0] sram_sel_2_2;
  logic [MODE_WIDTH-1:0]    wr_addr_2_2;
  logic                     wr_en_2_2;
  logic [CFG_BUS_WIDTH-1:0] wr_cfg_2_2;

  logic [SEL_WIDTH_2_1-1:0] sram_sel_2_1;
  logic [MODE_WIDTH-1:0]    wr_addr_2_1;
  logic                     wr_en_2_1;
  logic [CFG_BUS_WIDTH-1:0] wr_cfg_2_1;

  // master: control-plane side driving commands and words
  modport master (
    output cmd_valid, cmd_target, cmd_addr, s_valid, s_data,
    input  cmd_ready, s_ready, busy, done, err,
    input  sram_sel_2_2, wr_addr_2_2, wr_en_2_2, wr_cfg_2_2,
    input  sram_sel_2_1, wr_addr_2_1, wr_en_2_1, wr_cfg_2_1
  );

  // slave: the loader itself
  modport slave (
    input  cmd_valid, cmd_target, cmd_addr, s_valid, s_data,
    output cmd_ready, s_ready, busy, done, err,
    output sram_sel_2_2, wr_addr_2_2, wr_en_2_2, wr_cfg_2_2,
    output sram_sel_2_1, wr_addr_2_1, wr_en_2_1, wr_cfg_2_1
  );

endinterface

// File: rtl/ibf_cfg_loader.sv
// Writes one mode entry of the 2:2 BF or 2:1 MUX config SRAM from a stream
// of 64-bit words, one registered write per accepted beat, slice ascending.
module ibf_cfg_loader
  import ibf_cfg_loader_pkg::*;
#(
  parameter int CFG_BUS_WIDTH = CFG_BUS_WIDTH_DEF,
  parameter int MODE_WIDTH    = 2,
  parameter int CFG_DEPTH     = 3,
  parameter int SEL_WIDTH_2_2 = 8,
  parameter int SEL_WIDTH_2_1 = 4,
  parameter int NUM_WORDS_2_2 = 4,
  parameter int NUM_WORDS_2_1 = 2
) (
  input  logic           clk,
  input  logic           rst,
  ibf_cfg_loader_if.slave bus
);

  localparam int CNT_W = cnt_width(NUM_WORDS_2_2, NUM_WORDS_2_1);
  localparam logic [CNT_W-1:0] LAST_22 = CNT_W'(NUM_WORDS_2_2 - 1);
  localparam logic [CNT_W-1:0] LAST_21 = CNT_W'(NUM_WORDS_2_1 - 1);

  if (NUM_WORDS_2_2 > (1 << SEL_WIDTH_2_2)) begin : g_chk_22
    $error("NUM_WORDS_2_2 does not fit in SEL_WIDTH_2_2");
  end
  if (NUM_WORDS_2_1 > (1 << SEL_WIDTH_2_1)) begin : g_chk_21
    $error("NUM_WORDS_2_1 does not fit in SEL_WIDTH_2_1");
  end

  state_e                   state_q, state_d;
  logic [MODE_WIDTH-1:0]    addr_q,  addr_d;
  logic [CNT_W-1:0]         cnt_q,   cnt_d;
  logic                     busy_q,  busy_d;
  logic                     done_q,  done_d;
  logic                     err_q,   err_d;

  logic                     wen22_q, wen22_d;
  logic [SEL_WIDTH_2_2-1:0] sel22_q, sel22_d;
  logic [MODE_WIDTH-1:0]    wad22_q, wad22_d;
  logic [CFG_BUS_WIDTH-1:0] cfg22_q, cfg22_d;

  logic                     wen21_q, wen21_d;
  logic [SEL_WIDTH_2_1-1:0] sel21_q, sel21_d;
  logic [MODE_WIDTH-1:0]    wad21_q, wad21_d;
  logic [CFG_BUS_WIDTH-1:0] cfg21_q, cfg21_d;

  logic beat;

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.s_ready   = (state_q != ST_IDLE);
  assign beat          = bus.s_valid && bus.s_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wen22_d = 1'b0;
    sel22_d = sel22_q;
    wad22_d = wad22_q;
    cfg22_d = cfg22_q;
    wen21_d = 1'b0;
    sel21_d = sel21_q;
    wad21_d = wad21_q;
    cfg21_d = cfg21_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (int'(bus.cmd_addr) >= CFG_DEPTH) begin
            err_d = 1'b1;
          end else begin
            addr_d  = bus.cmd_addr;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = (tgt_e'(bus.cmd_target) == TGT_2_1) ? ST_LOAD_21 : ST_LOAD_22;
          end
        end
      end

      ST_LOAD_22: begin
        if (beat) begin
          wen22_d = 1'b1;
          sel22_d = SEL_WIDTH_2_2'(cnt_q);
          wad22_d = addr_q;
          cfg22_d = bus.s_data;
          // Hold on the last beat instead of wrapping; the next command clears it.
          if (cnt_q == LAST_22) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_LOAD_21: begin
        if (beat) begin
          wen21_d = 1'b1;
          sel21_d = SEL_WIDTH_2_1'(cnt_q);
          wad21_d = addr_q;
          cfg21_d = bus.s_data;
          if (cnt_q == LAST_21) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset mid-load simply drops the entry; software reissues the command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wen22_q <= 1'b0;
      sel22_q <= '0;
      wad22_q <= '0;
      cfg22_q <= '0;
      wen21_q <= 1'b0;
      sel21_q <= '0;
      wad21_q <= '0;
      cfg21_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wen22_q <= wen22_d;
      sel22_q <= sel22_d;
      wad22_q <= wad22_d;
      cfg22_q <= cfg22_d;
      wen21_q <= wen21_d;
      sel21_q <= sel21_d;
      wad21_q <= wad21_d;
      cfg21_q <= cfg21_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.wr_en_2_2    = wen22_q;
  assign bus.sram_sel_2_2 = sel22_q;
  assign bus.wr_addr_2_2  = wad22_q;
  assign bus.wr_cfg_2_2   = cfg22_q;
  assign bus.wr_en_2_1    = wen21_q;
  assign bus.sram_sel_2_1 = sel21_q;
  assign bus.wr_addr_2_1  = wad21_q;
  assign bus.wr_cfg_2_1   = cfg21_q;

endmodule

// File: tb/tb_ibf_cfg_loader.sv
// Table-driven bench for ibf_cfg_loader plus hand sequences for back-to-back
// commands and reset in the middle of a load.
module tb_ibf_cfg_loader;

  typedef struct packed {
    logic       cr, sr, busy, done, err, we22;
    logic [7:0] sel22;
    logic [1:0] a22;
    logic [63:0] c22;
    logic       we21;
    logic [3:0] sel21;
    logic [1:0] a21;
    logic [63:0] c21;
  } obs_t;

  typedef struct {
    logic        rst, cv, tgt;
    logic [1:0]  addr;
    logic        sv;
    logic [63:0] data;
    obs_t        exp;
  } vec_t;

  localparam int NV = 17;

  logic clk;
  logic rst;
  int   nchk = 0;
  int   nerr = 0;
  vec_t vecs [NV];

  ibf_cfg_loader_if bus ();

  ibf_cfg_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input int cr, input int sr, input int bz, input int dn,
                              input int er, input int w22, input int s22, input int a22,
                              input logic [63:0] c22, input int w21, input int s21,
                              input int a21, input logic [63:0] c21);
    obs_t o;
    o.cr = cr[0];  o.sr = sr[0];  o.busy = bz[0]; o.done = dn[0]; o.err = er[0];
    o.we22 = w22[0]; o.sel22 = s22[7:0]; o.a22 = a22[1:0]; o.c22 = c22;
    o.we21 = w21[0]; o.sel21 = s21[3:0]; o.a21 = a21[1:0]; o.c21 = c21;
    return o;
  endfunction

  function automatic vec_t mkv(input int rs, input int cv, input int tg, input int ad,
                               input int sv, input logic [63:0] d, input obs_t e);
    vec_t v;
    v.rst = rs[0]; v.cv = cv[0]; v.tgt = tg[0]; v.addr = ad[1:0];
    v.sv = sv[0];  v.data = d;   v.exp = e;
    return v;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.cr = bus.cmd_ready; o.sr = bus.s_ready; o.busy = bus.busy;
    o.done = bus.done; o.err = bus.err;
    o.we22 = bus.wr_en_2_2; o.sel22 = bus.sram_sel_2_2;
    o.a22 = bus.wr_addr_2_2; o.c22 = bus.wr_cfg_2_2;
    o.we21 = bus.wr_en_2_1; o.sel21 = bus.sram_sel_2_1;
    o.a21 = bus.wr_addr_2_1; o.c21 = bus.wr_cfg_2_1;
    return o;
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic tg, input logic [1:0] ad,
                       input logic sv, input logic [63:0] d);
    bus.cmd_valid  = cv;
    bus.cmd_target = tg;
    bus.cmd_addr   = ad;
    bus.s_valid    = sv;
    bus.s_data     = d;
  endtask

  initial begin
    // inputs per row go in during that cycle; expectations are what is seen
    // in that cycle, i.e. the registered result of the previous rows.
    vecs[0]  = mkv(0,0,0,0, 1,64'hDEAD, mk(1,0,0,0,0, 0,0,0,64'h0,  0,0,0,64'h0));
    vecs[1]  = mkv(0,1,0,1, 0,64'h0,    mk(1,0,0,0,0, 0,0,0,64'h0,  0,0,0,64'h0));
    vecs[2]  = mkv(0,0,0,0, 1,64'hA0,   mk(0,1,1,0,0, 0,0,0,64'h0,  0,0,0,64'h0));
    vecs[3]  = mkv(0,0,0,0, 1,64'hA1,   mk(0,1,1,0,0, 1,0,1,64'hA0, 0,0,0,64'h0));
    vecs[4]  = mkv(0,0,0,0, 1,64'hA2,   mk(0,1,1,0,0, 1,1,1,64'hA1, 0,0,0,64'h0));
    vecs[5]  = mkv(0,0,0,0, 1,64'hA3,   mk(0,1,1,0,0, 1,2,1,64'hA2, 0,0,0,64'h0));
    vecs[6]  = mkv(0,0,0,0, 0,64'h0,    mk(1,0,0,1,0, 1,3,1,64'hA3, 0,0,0,64'h0));
    vecs[7]  = mkv(0,1,1,2, 0,64'h0,    mk(1,0,0,0,0, 0,3,1,64'hA3, 0,0,0,64'h0));
    vecs[8]  = mkv(0,0,0,0, 1,64'hB0,   mk(0,1,1,0,0, 0,3,1,64'hA3, 0,0,0,64'h0));
    vecs[9]  = mkv(0,0,0,0, 0,64'h0,    mk(0,1,1,0,0, 0,3,1,64'hA3, 1,0,2,64'hB0));
    vecs[10] = mkv(0,0,0,0, 0,64'h0,    mk(0,1,1,0,0, 0,3,1,64'hA3, 0,0,2,64'hB0));
    vecs[11] = mkv(0,0,0,0, 0,64'h0,    mk(0,1,1,0,0, 0,3,1,64'hA3, 0,0,2,64'hB0));
    vecs[12] = mkv(0,0,0,0, 1,64'hB1,   mk(0,1,1,0,0, 0,3,1,64'hA3, 0,0,2,64'hB0));
    vecs[13] = mkv(0,0,0,0, 0,64'h0,    mk(1,0,0,1,0, 0,3,1,64'hA3, 1,1,2,64'hB1));
    vecs[14] = mkv(0,1,0,3, 0,64'h0,    mk(1,0,0,0,0, 0,3,1,64'hA3, 0,1,2,64'hB1));
    vecs[15] = mkv(0,0,0,0, 1,64'h55,   mk(1,0,0,0,1, 0,3,1,64'hA3, 0,1,2,64'hB1));
    vecs[16] = mkv(0,0,0,0, 0,64'h0,    mk(1,0,0,0,0, 0,3,1,64'hA3, 0,1,2,64'hB1));

    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 64'h0);
    @(negedge clk);
    @(negedge clk);
    check("reset", mk(1,0,0,0,0, 0,0,0,64'h0, 0,0,0,64'h0));
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].exp);
      rst = vecs[i].rst;
      drive(vecs[i].cv, vecs[i].tgt, vecs[i].addr, vecs[i].sv, vecs[i].data);
    end

    // back-to-back: 2:1 addr0 then 2:2 addr2 with cmd_valid held throughout
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd0, 1'b1, 64'hC0);
    @(negedge clk);
    check("b2b_load21", mk(0,1,1,0,0, 0,3,1,64'hA3, 0,1,2,64'hB1));
    drive(1'b1, 1'b0, 2'd2, 1'b1, 64'hC0);
    @(negedge clk);
    check("b2b_w21_0", mk(0,1,1,0,0, 0,3,1,64'hA3, 1,0,0,64'hC0));
    drive(1'b1, 1'b0, 2'd2, 1'b1, 64'hC1);
    @(negedge clk);
    check("b2b_done21", mk(1,0,0,1,0, 0,3,1,64'hA3, 1,1,0,64'hC1));
    drive(1'b1, 1'b0, 2'd2, 1'b1, 64'hD0);
    @(negedge clk);
    check("b2b_load22", mk(0,1,1,0,0, 0,3,1,64'hA3, 0,1,0,64'hC1));
    drive(1'b0, 1'b0, 2'd0, 1'b1, 64'hD0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("b2b_w22_%0d", k - 1),
            mk(0,1,1,0,0, 1,k-1,2,64'hD0 + 64'(k - 1), 0,1,0,64'hC1));
      drive(1'b0, 1'b0, 2'd0, 1'b1, 64'hD0 + 64'(k));
    end
    @(negedge clk);
    check("b2b_done22", mk(1,0,0,1,0, 1,3,2,64'hD3, 0,1,0,64'hC1));

    // reset after two of four 2:2 beats
    drive(1'b1, 1'b0, 2'd0, 1'b0, 64'h0);
    @(negedge clk);
    check("rst_load22", mk(0,1,1,0,0, 0,3,2,64'hD3, 0,1,0,64'hC1));
    drive(1'b0, 1'b0, 2'd0, 1'b1, 64'hE0);
    @(negedge clk);
    check("rst_w0", mk(0,1,1,0,0, 1,0,0,64'hE0, 0,1,0,64'hC1));
    drive(1'b0, 1'b0, 2'd0, 1'b1, 64'hE1);
    @(negedge clk);
    check("rst_w1", mk(0,1,1,0,0, 1,1,0,64'hE1, 0,1,0,64'hC1));
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 1'b1, 64'hE2);
    @(negedge clk);
    check("rst_mid_load", mk(1,0,0,0,0, 0,0,0,64'h0, 0,0,0,64'h0));
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'd1, 1'b0, 64'h0);
    @(negedge clk);
    check("rst_reload", mk(0,1,1,0,0, 0,0,0,64'h0, 0,0,0,64'h0));
    drive(1'b0, 1'b0, 2'd0, 1'b1, 64'hF0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("reload_w%0d", k - 1),
            mk(0,1,1,0,0, 1,k-1,1,64'hF0 + 64'(k - 1), 0,0,0,64'h0));
      drive(1'b0, 1'b0, 2'd0, 1'b1, 64'hF0 + 64'(k));
    end
    @(negedge clk);
    check("reload_done", mk(1,0,0,1,0, 1,3,1,64'hF3, 0,0,0,64'h0));
    drive(1'b0, 1'b0, 2'd0, 1'b0, 64'h0);
    @(negedge clk);
    check("reload_idle", mk(1,0,0,0,0, 0,3,1,64'hF3, 0,0,0,64'h0));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
